// File: rtl/mcdf_pkt_sched.sv
// MCDF packet scheduler: picks an enabled channel holding a full packet
// (lowest prio value first, round-robin on ties) and drains it to the formatter.
module mcdf_pkt_sched #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NCH    = 3,
    parameter int unsigned LEN_W  = 6,
    parameter int unsigned CNT_W  = 7,
    parameter int unsigned DEPTH  = 32
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [NCH-1:0]          slv_en_i,
    input  logic [2*NCH-1:0]        slv_prio_i,
    input  logic [LEN_W*NCH-1:0]    slv_len_i,
    input  logic [CNT_W*NCH-1:0]    slv_cnt_i,
    input  logic [DATA_W*NCH-1:0]   slv_data_i,
    output logic [NCH-1:0]          slv_rd_o,
    input  logic                    fmt_grant_i,
    output logic                    fmt_req_o,
    output logic [1:0]              fmt_chid_o,
    output logic [LEN_W-1:0]        fmt_length_o,
    output logic [DATA_W-1:0]       fmt_data_o,
    output logic                    fmt_start_o,
    output logic                    fmt_end_o,
    output logic                    busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SEND,
        ST_TAIL,
        ST_GAP
    } state_t;

    state_t state, state_nxt;

    logic [1:0]        chid_q;
    logic [1:0]        rr_last;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  rem_q;
    logic [DATA_W-1:0] data_q;
    logic              vld_q;
    logic              start_q;
    logic              end_q;

    logic [1:0]        arb_base;
    logic [1:0]        ch;
    logic [LEN_W-1:0]  c_len;
    logic [CNT_W-1:0]  c_cnt;
    logic [1:0]        c_prio;
    logic              sel_vld;
    logic [1:0]        sel_chid;
    logic [LEN_W-1:0]  sel_len;
    logic [1:0]        best_prio;
    logic              arb_take;
    logic              pop;
    logic [DATA_W-1:0] head;
    logic              hold;

    // GAP arbitrates against the just-finished channel, so a new request
    // can follow the end word by two cycles while rr_last catches up.
    always_comb begin
        sel_vld   = 1'b0;
        sel_chid  = '0;
        sel_len   = '0;
        best_prio = '0;
        ch        = '0;
        c_len     = '0;
        c_cnt     = '0;
        c_prio    = '0;
        arb_base  = (state == ST_GAP) ? chid_q : rr_last;
        for (int unsigned k = 1; k <= NCH; k++) begin
            ch     = 2'((32'(arb_base) + k) % NCH);
            c_len  = slv_len_i[ch*LEN_W +: LEN_W];
            c_cnt  = slv_cnt_i[ch*CNT_W +: CNT_W];
            c_prio = slv_prio_i[ch*2 +: 2];
            if (slv_en_i[ch] && (c_len != '0) && (32'(c_len) <= DEPTH) &&
                (32'(c_cnt) >= 32'(c_len)) && (!sel_vld || (c_prio < best_prio))) begin
                sel_vld   = 1'b1;
                sel_chid  = ch;
                sel_len   = c_len;
                best_prio = c_prio;
            end
        end
    end

    always_comb begin
        arb_take = ((state == ST_IDLE) || (state == ST_GAP)) && sel_vld;
        pop      = (state == ST_SEND);
        head     = slv_data_i[chid_q*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (sel_vld) state_nxt = ST_REQ;
            ST_REQ:  if (fmt_grant_i) state_nxt = ST_SEND;
            ST_SEND: if (rem_q == LEN_W'(1)) state_nxt = ST_TAIL;
            ST_TAIL: state_nxt = ST_GAP;
            ST_GAP:  state_nxt = sel_vld ? ST_REQ : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        hold         = (state == ST_REQ) || (state == ST_SEND) || (state == ST_TAIL);
        fmt_req_o    = (state == ST_REQ);
        busy_o       = (state != ST_IDLE);
        slv_rd_o     = '0;
        if (pop) slv_rd_o[chid_q] = 1'b1;
        fmt_chid_o   = hold ? chid_q : '0;
        fmt_length_o = hold ? len_q : '0;
        fmt_data_o   = vld_q ? data_q : '0;
        fmt_start_o  = start_q;
        fmt_end_o    = end_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            chid_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            rr_last <= 2'(NCH - 1);
            data_q  <= '0;
            vld_q   <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            vld_q   <= pop;
            start_q <= pop && (rem_q == len_q);
            end_q   <= pop && (rem_q == LEN_W'(1));
            if (pop) begin
                data_q <= head;
                rem_q  <= rem_q - LEN_W'(1);
            end
            if (state == ST_GAP) rr_last <= chid_q;
            if (arb_take) begin
                chid_q <= sel_chid;
                len_q  <= sel_len;
                rem_q  <= sel_len;
            end
        end
    end

endmodule

// File: tb/tb_mcdf_pkt_sched.sv
// Scoreboard bench for mcdf_pkt_sched: FIFO models feed the scheduler, a
// transaction-level model predicts the packet sequence, a monitor checks frames.
module tb_mcdf_pkt_sched;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  slv_en;
    logic [5:0]  slv_prio;
    logic [17:0] slv_len;
    logic [20:0] slv_cnt;
    logic [95:0] slv_data;
    logic [2:0]  slv_rd;
    logic        grant;
    logic        req;
    logic [1:0]  chid;
    logic [5:0]  length;
    logic [31:0] data;
    logic        start;
    logic        fend;
    logic        busy;

    mcdf_pkt_sched #(
        .DATA_W(32),
        .NCH   (3),
        .LEN_W (6),
        .CNT_W (7),
        .DEPTH (32)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .slv_en_i    (slv_en),
        .slv_prio_i  (slv_prio),
        .slv_len_i   (slv_len),
        .slv_cnt_i   (slv_cnt),
        .slv_data_i  (slv_data),
        .slv_rd_o    (slv_rd),
        .fmt_grant_i (grant),
        .fmt_req_o   (req),
        .fmt_chid_o  (chid),
        .fmt_length_o(length),
        .fmt_data_o  (data),
        .fmt_start_o (start),
        .fmt_end_o   (fend),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int chid;
        int len;
    } pkt_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] fifo[3][$];
    int          cfg_en[3];
    int          cfg_prio[3];
    int          cfg_len[3];
    int          m_rr = 2;
    int          gmode = 0;
    pkt_t        exp_q[$];
    logic [31:0] exp_words[$];
    int          got_chids[$];
    int          start_times[$];
    bit          in_pkt = 1'b0;
    int          pops = 0;
    logic [31:0] cap_words[$];
    int          cap_chid;
    int          cap_len;
    logic [2:0]  rd_neg = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic refresh();
        for (int c = 0; c < 3; c++) begin
            slv_cnt[c*7 +: 7]   = 7'(fifo[c].size());
            slv_data[c*32 +: 32] = (fifo[c].size() > 0) ? fifo[c][0] : '0;
        end
    endtask

    task automatic apply_cfg();
        for (int c = 0; c < 3; c++) begin
            slv_en[c]          = (cfg_en[c] != 0);
            slv_prio[c*2 +: 2] = 2'(cfg_prio[c]);
            slv_len[c*6 +: 6]  = 6'(cfg_len[c]);
        end
    endtask

    // Serve packets from a snapshot of the FIFOs until no channel qualifies.
    task automatic compute_expected();
        logic [31:0] mq[3][$];
        int best;
        int c;
        pkt_t p;
        for (int i = 0; i < 3; i++) mq[i] = fifo[i];
        forever begin
            best = -1;
            for (int k = 1; k <= 3; k++) begin
                c = (m_rr + k) % 3;
                if (cfg_en[c] != 0 && cfg_len[c] > 0 && cfg_len[c] <= 32 &&
                    mq[c].size() >= cfg_len[c]) begin
                    if (best < 0 || cfg_prio[c] < cfg_prio[best]) best = c;
                end
            end
            if (best < 0) break;
            p.chid = best;
            p.len  = cfg_len[best];
            exp_q.push_back(p);
            for (int w = 0; w < cfg_len[best]; w++) exp_words.push_back(mq[best].pop_front());
            m_rr = best;
        end
    endtask

    task automatic begin_phase(input int f0, input int f1, input int f2);
        int f[3];
        f = '{f0, f1, f2};
        @(negedge clk);
        slv_en = '0;
        for (int c = 0; c < 3; c++) begin
            fifo[c].delete();
            for (int w = 0; w < f[c]; w++) fifo[c].push_back($urandom);
        end
        refresh();
        compute_expected();
        apply_cfg();
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy || in_pkt) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_in_time"}, (n < budget), 1);
        repeat (4) @(negedge clk);
        chk({name, "_idle_after"}, {busy, req}, 0);
    endtask

    // FIFO models: pop on strobes seen in the previous cycle, then re-present.
    always @(negedge clk) rd_neg = slv_rd;

    always @(posedge clk) begin
        cyc++;
        #1;
        for (int c = 0; c < 3; c++)
            if (rd_neg[c] && fifo[c].size() > 0) void'(fifo[c].pop_front());
        refresh();
    end

    always @(negedge clk) begin
        case (gmode)
            1:       grant = 1'b1;
            2:       grant = ($urandom % 3) == 0;
            default: grant = 1'b0;
        endcase
    end

    task automatic check_pkt();
        pkt_t e;
        logic [31:0] w;
        logic [31:0] act_w;
        logic [31:0] exp_w;
        bit bad;
        got_chids.push_back(cap_chid);
        if (exp_q.size() == 0) begin
            chk("unexpected_pkt", cap_chid, 99);
        end else begin
            e = exp_q.pop_front();
            chk("pkt_chid", cap_chid, e.chid);
            chk("pkt_len", cap_len, e.len);
            chk("pkt_pops", pops, e.len);
            chk("pkt_nwords", cap_words.size(), e.len);
            bad   = 1'b0;
            act_w = '0;
            exp_w = '0;
            for (int i = 0; i < e.len; i++) begin
                w = (exp_words.size() > 0) ? exp_words.pop_front() : '0;
                if (!bad) begin
                    act_w = (i < cap_words.size()) ? cap_words[i] : '0;
                    exp_w = w;
                    if (act_w !== exp_w) bad = 1'b1;
                end
            end
            chk("pkt_data", act_w, exp_w);
        end
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            in_pkt = 1'b0;
            pops   = 0;
            cap_words.delete();
        end else begin
            if (slv_rd != '0) begin
                pops++;
                chk("rd_onehot_chid", slv_rd, 3'(1) << chid);
            end
            if (start) begin
                chk("start_inside_pkt", in_pkt, 0);
                in_pkt   = 1'b1;
                cap_chid = chid;
                cap_len  = length;
                cap_words.delete();
                start_times.push_back(cyc);
            end
            if (in_pkt) cap_words.push_back(data);
            else if (data != '0) chk("data_when_idle", data, 0);
            if (fend) begin
                if (!in_pkt) chk("end_without_start", 0, 1);
                else check_pkt();
                in_pkt = 1'b0;
                pops   = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        int s0;
        int n;
        int p;
        int r;
        int t3_ord[4];
        t3_ord = '{0, 1, 2, 0};
        rstn = 1'b0;
        slv_en = '0; slv_prio = '0; slv_len = '0; slv_cnt = '0; slv_data = '0; grant = 1'b0;
        cfg_en = '{0, 0, 0}; cfg_prio = '{0, 0, 0}; cfg_len = '{0, 0, 0};
        repeat (3) @(negedge clk);
        chk("reset_outputs", {slv_rd, req, chid, length, data, start, fend, busy}, 0);
        rstn = 1'b1;

        // Round-robin tie with grant held high
        cfg_en = '{1, 1, 1}; cfg_prio = '{1, 1, 1}; cfg_len = '{3, 3, 3};
        gmode = 1;
        g0 = got_chids.size();
        s0 = start_times.size();
        begin_phase(6, 3, 3);
        wait_done(300, "t3");
        chk("t3_count", got_chids.size() - g0, 4);
        if (got_chids.size() - g0 == 4) begin
            for (int i = 0; i < 4; i++) chk("t3_order", got_chids[g0+i], t3_ord[i]);
            for (int i = 1; i < 4; i++)
                chk("t3_start_gap", start_times[s0+i] - start_times[s0+i-1], 6);
        end

        // Priority beats round-robin order
        cfg_en = '{1, 0, 1}; cfg_prio = '{2, 0, 0}; cfg_len = '{2, 2, 2};
        gmode = 2;
        g0 = got_chids.size();
        begin_phase(2, 2, 2);
        wait_done(300, "t2");
        chk("t2_count", got_chids.size() - g0, 2);
        if (got_chids.size() - g0 == 2) begin
            chk("t2_first", got_chids[g0], 2);
            chk("t2_second", got_chids[g0+1], 0);
        end

        // Single channel with a stalled grant
        gmode = 0;
        grant = 1'b0;
        cfg_en = '{0, 1, 0}; cfg_prio = '{0, 0, 0}; cfg_len = '{0, 4, 0};
        begin_phase(0, 4, 0);
        @(negedge clk);
        chk("t1_req", req, 1);
        chk("t1_chid", chid, 1);
        chk("t1_length", length, 4);
        repeat (10) begin
            @(negedge clk);
            chk("t4_stall", {req, chid, length, slv_rd}, {1'b1, 2'd1, 6'd4, 3'b000});
        end
        gmode = 1;
        n = 0;
        while (req && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("t1_grant_in_time", (n < 5), 1);
        chk("t1_first_pop", slv_rd, 3'b010);
        wait_done(100, "t1");

        // Length boundaries: 0 and 40 never served, 1 frames start and end together
        cfg_en = '{1, 1, 1}; cfg_prio = '{0, 1, 0}; cfg_len = '{0, 1, 40};
        gmode = 2;
        begin_phase(8, 3, 32);
        wait_done(300, "t5a");
        chk("t5_len0_untouched", fifo[0].size(), 8);
        chk("t5_len40_untouched", fifo[2].size(), 32);

        // One word short of a packet, then the last word arrives
        cfg_en = '{1, 0, 0}; cfg_prio = '{0, 0, 0}; cfg_len = '{5, 0, 0};
        begin_phase(4, 0, 0);
        repeat (10) begin
            @(negedge clk);
            chk("t5_short_no_req", {req, busy}, 0);
        end
        fifo[0].push_back($urandom);
        refresh();
        compute_expected();
        wait_done(300, "t5b");

        // Randomized configurations
        repeat (12) begin
            for (int c = 0; c < 3; c++) begin
                cfg_en[c]   = (($urandom % 4) != 0) ? 1 : 0;
                cfg_prio[c] = $urandom % 4;
                r = $urandom % 8;
                cfg_len[c]  = (r == 0) ? 0 : (r == 1) ? 33 + ($urandom % 20) : 1 + ($urandom % 6);
            end
            gmode = (($urandom % 2) != 0) ? 1 : 2;
            begin_phase($urandom_range(0, 16), $urandom_range(0, 16), $urandom_range(0, 16));
            wait_done(2000, "rand");
        end

        // Reset in the middle of a packet
        cfg_en = '{1, 0, 0}; cfg_prio = '{0, 0, 0}; cfg_len = '{8, 0, 0};
        gmode = 1;
        begin_phase(8, 0, 0);
        n = 0;
        p = 0;
        while (p < 2 && n < 50) begin
            @(negedge clk);
            n++;
            if (slv_rd[0]) p++;
        end
        chk("t6_pops_seen", p, 2);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_reset_outputs", {slv_rd, req, chid, length, data, start, fend, busy}, 0);
        exp_q.delete();
        exp_words.delete();
        repeat (2) @(negedge clk);
        for (int c = 0; c < 3; c++) fifo[c].delete();
        refresh();
        m_rr = 2;
        rstn = 1'b1;
        cfg_en = '{1, 1, 0}; cfg_prio = '{1, 1, 0}; cfg_len = '{2, 2, 0};
        g0 = got_chids.size();
        begin_phase(2, 2, 0);
        wait_done(300, "t6");
        chk("t6_count", got_chids.size() - g0, 2);
        if (got_chids.size() - g0 == 2) begin
            chk("t6_ch0_first", got_chids[g0], 0);
            chk("t6_ch1_second", got_chids[g0+1], 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
